switch_mmio_port: RTL and testbench
===================================

Name: switch_mmio_port

Overview:
Memory-mapped input peripheral that lets the CPU read the board switches. It is the inbound counterpart of the seven-segment output path. The block synchronizes and debounces `switches`, latches a sticky change flag and an edge counter, and answers CPU load/store accesses in a 4-word address window. It sits beside the data memory in `mem_cpu`; its `hit` output steers the CPU read-data mux.

Parameters:
- `SW_WIDTH`, 8: number of switch inputs.
- `ADDR_WIDTH`, 16: CPU address width.
- `DATA_WIDTH`, 16: CPU data width; must be at least `SW_WIDTH` and at least 9.
- `BASE_ADDR`, 16'hFF00: word address of register 0; must be 4-aligned.
- `DEBOUNCE_CYCLES`, 50000: number of stable cycles required before accepting a new switch value; minimum 2.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `switches` in `SW_WIDTH`: raw, asynchronous board switches.
- `addr` in `ADDR_WIDTH`: CPU word address.
- `rd_en` in 1: read strobe, one cycle per access.
- `wren` in 1: write strobe.
- `wdata` in `DATA_WIDTH`: write data.
- `rdata` out `DATA_WIDTH`: registered read data.
- `rvalid` out 1: `rdata` is valid this cycle.
- `hit` out 1: combinational; `addr` is inside the window.
- `irq` out 1: registered interrupt request, equal to `change_flag & irq_en`.

Behaviour:
- **Reset** (synchronous, active-high): clears both synchronizer flops, `candidate`, `stable`, `count`, `change_flag`, `irq_en`, `event_count`, `rdata`, `rvalid` and `irq`. Reset asserted mid-debounce discards the pending value.
- **Synchronizer**: two-flop chain, `sw_s1` feeding `sw_s2`.
- **Debounce** (whole vector, one counter of width clog2(`DEBOUNCE_CYCLES`)):
  - If `sw_s2 != candidate`: `candidate <= sw_s2` and `count <= 0`.
  - Else if `count < DEBOUNCE_CYCLES-1`: `count++`.
  - Else, if `stable != candidate`: `stable <= candidate`, set `change_flag`, `event_count++`. The counter then holds.
- **Latency**: a clean input change becomes visible in `stable` on edge `DEBOUNCE_CYCLES+3`. A bounce restarts the count, and no intermediate value ever reaches `stable`.
- **Register map** (offset = `addr - BASE_ADDR`; `hit` is 1 when `addr[ADDR_WIDTH-1:2] == BASE_ADDR[ADDR_WIDTH-1:2]`):
  - `+0` DATA (RO): `stable`, zero-extended.
  - `+1` STATUS: bit0 `change_flag` (W1C); bit8 `irq_en` (RW). Other bits read 0.
  - `+2` RAW (RO): `sw_s2`, zero-extended.
  - `+3` EVCNT: `event_count`, `DATA_WIDTH` bits, wraps at 2^`DATA_WIDTH`. Any write clears it.
- **Read timing**: when `rd_en` and `hit` are both high, `rdata` and `rvalid` are driven on the next edge. `rvalid` lasts exactly one cycle. Back-to-back reads are allowed, with one result per cycle.
- **Idle and unmapped accesses**: when there is no read hit, `rdata` = 0 and `rvalid` = 0. Writes that miss the window, or target RO registers, are ignored.
- **Simultaneous events**:
  - Change-detect set together with a W1C clear: set wins and the flag stays 1.
  - Increment together with an EVCNT write: the clear wins and the result is 0.
  - `rd_en` and `wren` to the same register in the same cycle: the read returns the pre-write value.
- **`irq`**: registered; it asserts one cycle after both `change_flag` and `irq_en` are 1.
- No back-pressure: the CPU never stalls on this block.

Decomposition:
- Shared package `mmio_pkg`, holding:
  - `SW_BASE_ADDR`;
  - offset constants `SW_REG_DATA=0`, `SW_REG_STATUS=1`, `SW_REG_RAW=2`, `SW_REG_EVCNT=3`;
  - status bit positions `ST_CHANGE=0`, `ST_IRQ_EN=8`.
- One sub-module, `sync_debounce`, taking parameters `WIDTH` and `CYCLES`. It contains the synchronizer and debounce counter, and outputs `sw_sync`, `stable` and a one-cycle `changed` pulse.
- The top level holds the register file, the read path and `irq`.

Test Plan (all with `DEBOUNCE_CYCLES`=4):
- **Reset**: hold `switches`=8'h03 through reset, then release → `stable`=0 right after reset; DATA reads 16'h0003 from edge 7 after release; STATUS=16'h0001; EVCNT=1.
- **Bounce**: toggle bit0 between 0 and 1 every 2 cycles for 20 cycles, then settle at 1 → `stable` never changes during the bouncing; exactly one update, 7 edges after settling; EVCNT increments by 1.
- **Read protocol**: `rd_en` at FF00, FF01, FF02 back-to-back → `rvalid` high for 3 consecutive cycles with matching data; a read at FF04 gives `hit`=0, `rvalid`=0, `rdata`=0.
- **W1C race**: write 16'h0001 to STATUS on the same edge that a debounced change lands → `change_flag` remains 1; a later write of 16'h0001 → reads back 16'h0000.
- **Interrupt**: write 16'h0100 to STATUS, then change switches 8'h03→8'hA5 → `irq` rises one cycle after `change_flag` sets; W1C drops `irq` one cycle later; EVCNT write of 0 → EVCNT reads 0.
- **Reset mid-debounce**: change switches, then pulse `reset` 2 cycles later → all registers read 0, and debounce restarts from scratch (7 edges after `reset` deasserts).

Source files
------------

// File: rtl/mmio_pkg.sv
// Shared constants for the CPU memory-mapped peripherals.
//   SW_BASE_ADDR  : default word address of the switch port window
//   sw_reg_e      : register offsets inside the 4-word switch window
//   ST_CHANGE     : STATUS bit holding the sticky change flag (write 1 to clear)
//   ST_IRQ_EN     : STATUS bit holding the interrupt enable
package mmio_pkg;

   localparam logic [15:0] SW_BASE_ADDR = 16'hFF00;

   typedef enum logic [1:0] {
      SW_REG_DATA   = 2'd0,
      SW_REG_STATUS = 2'd1,
      SW_REG_RAW    = 2'd2,
      SW_REG_EVCNT  = 2'd3
   } sw_reg_e;

   localparam int unsigned ST_CHANGE = 0;
   localparam int unsigned ST_IRQ_EN = 8;

endpackage

// File: rtl/sync_debounce.sv
// Two-flop synchronizer followed by a whole-vector debouncer.
//   clk, reset : system clock, synchronous active-high reset
//   sw_i       : raw asynchronous inputs
//   sw_sync_o  : synchronized (not debounced) inputs
//   stable_o   : debounced value; only a value held for CYCLES compares is accepted
//   changed_o  : high for the one cycle in which stable_o is about to take a new value
module sync_debounce #(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned CYCLES = 50000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] sw_i,
   output logic [WIDTH-1:0] sw_sync_o,
   output logic [WIDTH-1:0] stable_o,
   output logic             changed_o
);

   localparam int unsigned     CntW   = $clog2(CYCLES);
   localparam logic [CntW-1:0] CntMax = CntW'(CYCLES - 1);

   logic [WIDTH-1:0] sw_s1_q, sw_s2_q;
   logic [WIDTH-1:0] cand_q, cand_d;
   logic [WIDTH-1:0] stable_q, stable_d;
   logic [CntW-1:0]  count_q, count_d;

   // The counter saturates at CntMax, so "settled" stays true while the input holds.
   assign changed_o = (sw_s2_q == cand_q) && (count_q == CntMax) && (stable_q != cand_q);

   always_comb begin
      cand_d   = cand_q;
      count_d  = count_q;
      stable_d = stable_q;
      if (sw_s2_q != cand_q) begin
         cand_d  = sw_s2_q;
         count_d = '0;
      end else if (count_q != CntMax) begin
         count_d = count_q + 1'b1;
      end else if (changed_o) begin
         stable_d = cand_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sw_s1_q  <= '0;
         sw_s2_q  <= '0;
         cand_q   <= '0;
         count_q  <= '0;
         stable_q <= '0;
      end else begin
         sw_s1_q  <= sw_i;
         sw_s2_q  <= sw_s1_q;
         cand_q   <= cand_d;
         count_q  <= count_d;
         stable_q <= stable_d;
      end
   end

   assign sw_sync_o = sw_s2_q;
   assign stable_o  = stable_q;

endmodule

// File: rtl/switch_mmio_port.sv
// Memory-mapped switch input port: debounced switches, sticky change flag,
// change-event counter and interrupt, in a 4-word CPU window.
//   clk, reset     : system clock, synchronous active-high reset
//   switches       : raw board switches
//   addr           : CPU word address; hit is combinational window decode
//   rd_en          : read strobe; rdata/rvalid follow on the next edge
//   wren, wdata    : write strobe and data
//   rdata, rvalid  : registered read response, zero when no read hit
//   irq            : registered change_flag & irq_en
module switch_mmio_port
   import mmio_pkg::*;
#(
   parameter int unsigned           SW_WIDTH        = 8,
   parameter int unsigned           ADDR_WIDTH      = 16,
   parameter int unsigned           DATA_WIDTH      = 16,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR       = ADDR_WIDTH'(SW_BASE_ADDR),
   parameter int unsigned           DEBOUNCE_CYCLES = 50000
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [SW_WIDTH-1:0]   switches,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic                  rd_en,
   input  logic                  wren,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic                  rvalid,
   output logic                  hit,
   output logic                  irq
);

   logic [SW_WIDTH-1:0] sw_sync, stable;
   logic                changed;

   sync_debounce #(
      .WIDTH  (SW_WIDTH),
      .CYCLES (DEBOUNCE_CYCLES)
   ) u_sync_debounce (
      .clk       (clk),
      .reset     (reset),
      .sw_i      (switches),
      .sw_sync_o (sw_sync),
      .stable_o  (stable),
      .changed_o (changed)
   );

   sw_reg_e reg_sel;
   logic    rd_hit, wr_status, wr_evcnt;

   assign hit       = (addr[ADDR_WIDTH-1:2] == BASE_ADDR[ADDR_WIDTH-1:2]);
   assign reg_sel   = sw_reg_e'(addr[1:0]);
   assign rd_hit    = rd_en && hit;
   assign wr_status = wren && hit && (reg_sel == SW_REG_STATUS);
   assign wr_evcnt  = wren && hit && (reg_sel == SW_REG_EVCNT);

   logic                  change_flag_q, change_flag_d;
   logic                  irq_en_q, irq_en_d;
   logic [DATA_WIDTH-1:0] event_count_q, event_count_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                  rvalid_q, irq_q;
   logic [DATA_WIDTH-1:0] status_word, rd_word;

   // Only two STATUS bits and nothing else of wdata are architected.
   logic unused_wdata;
   assign unused_wdata = ^wdata;

   always_comb begin
      status_word            = '0;
      status_word[ST_CHANGE] = change_flag_q;
      status_word[ST_IRQ_EN] = irq_en_q;
      rd_word                = '0;
      unique case (reg_sel)
         SW_REG_DATA:   rd_word = DATA_WIDTH'(stable);
         SW_REG_STATUS: rd_word = status_word;
         SW_REG_RAW:    rd_word = DATA_WIDTH'(sw_sync);
         SW_REG_EVCNT:  rd_word = event_count_q;
         default:       rd_word = '0;
      endcase
   end

   always_comb begin
      // A change landing in the same cycle as a W1C keeps the flag set.
      change_flag_d = change_flag_q;
      if (wr_status && wdata[ST_CHANGE]) change_flag_d = 1'b0;
      if (changed) change_flag_d = 1'b1;

      irq_en_d = wr_status ? wdata[ST_IRQ_EN] : irq_en_q;

      // A write clears the counter even if an event lands in the same cycle.
      event_count_d = event_count_q + DATA_WIDTH'(changed);
      if (wr_evcnt) event_count_d = '0;

      // Read sees pre-write state since rd_word comes from the _q registers.
      rdata_d = rd_hit ? rd_word : '0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         change_flag_q <= 1'b0;
         irq_en_q      <= 1'b0;
         event_count_q <= '0;
         rdata_q       <= '0;
         rvalid_q      <= 1'b0;
         irq_q         <= 1'b0;
      end else begin
         change_flag_q <= change_flag_d;
         irq_en_q      <= irq_en_d;
         event_count_q <= event_count_d;
         rdata_q       <= rdata_d;
         rvalid_q      <= rd_hit;
         irq_q         <= change_flag_q & irq_en_q;
      end
   end

   assign rdata  = rdata_q;
   assign rvalid = rvalid_q;
   assign irq    = irq_q;

endmodule

// File: tb/tb_switch_mmio_port.sv
// Scoreboard bench for switch_mmio_port with a short debounce time.
// The reference model treats the debouncer as a sliding window: a value is
// accepted once the raw switches sampled on DC+1 consecutive edges agree, two
// edges of synchronizer delay later.
module tb_switch_mmio_port;

   localparam int unsigned DC   = 4;
   localparam int unsigned HLEN = DC + 2;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  switches;
   logic [15:0] addr, wdata, rdata;
   logic        rd_en, wren, rvalid, hit, irq;

   always #5 clk = ~clk;

   switch_mmio_port #(
      .SW_WIDTH        (8),
      .ADDR_WIDTH      (16),
      .DATA_WIDTH      (16),
      .BASE_ADDR       (16'hFF00),
      .DEBOUNCE_CYCLES (DC)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .switches (switches),
      .addr     (addr),
      .rd_en    (rd_en),
      .wren     (wren),
      .wdata    (wdata),
      .rdata    (rdata),
      .rvalid   (rvalid),
      .hit      (hit),
      .irq      (irq)
   );

   // Reference model state. h[0] is the switch value sampled one edge ago.
   logic [7:0]  h [HLEN];
   logic [7:0]  m_stable = '0;
   logic        m_flag   = 1'b0;
   logic        m_en     = 1'b0;
   logic [15:0] m_ev     = '0;
   logic        m_irq    = 1'b0;
   logic [15:0] exp_q [$];

   int vectors     = 0;
   int miscompares = 0;
   logic mon_en    = 1'b0;

   initial for (int k = 0; k < HLEN; k++) h[k] = '0;

   function automatic logic will_land();
      logic same;
      same = 1'b1;
      for (int k = 2; k <= DC + 1; k++) if (h[k] != h[1]) same = 1'b0;
      return same && (h[1] != m_stable);
   endfunction

   function automatic logic in_window(input logic [15:0] a);
      return (a >= 16'hFF00) && (a <= 16'hFF03);
   endfunction

   // Drive one cycle of inputs, predict the effect of the coming edge, then commit.
   task automatic cyc(input logic r, input logic [7:0] sw, input logic [15:0] a,
                      input logic rd, input logic wr, input logic [15:0] wd);
      logic [7:0]  n_stable;
      logic        n_flag, n_en, n_irq, push, land, win;
      logic [15:0] n_ev, rv, offs;
      reset = r; switches = sw; addr = a; rd_en = rd; wren = wr; wdata = wd;
      win  = in_window(a);
      offs = a - 16'hFF00;
      push = 1'b0;
      rv   = '0;
      if (r) begin
         n_stable = '0; n_flag = 1'b0; n_en = 1'b0; n_ev = '0; n_irq = 1'b0;
      end else begin
         land = will_land();
         if (rd && win) begin
            push = 1'b1;
            case (offs)
               16'd0:   rv = {8'h00, m_stable};
               16'd1:   rv = {7'b0, m_en, 7'b0, m_flag};
               16'd2:   rv = {8'h00, h[1]};
               default: rv = m_ev;
            endcase
         end
         n_stable = land ? h[1] : m_stable;
         n_flag = m_flag;
         if (wr && win && offs == 16'd1 && wd[0]) n_flag = 1'b0;
         if (land) n_flag = 1'b1;
         n_en = (wr && win && offs == 16'd1) ? wd[8] : m_en;
         n_ev = m_ev + {15'b0, land};
         if (wr && win && offs == 16'd3) n_ev = '0;
         n_irq = m_flag & m_en;
      end
      @(posedge clk);
      m_stable = n_stable; m_flag = n_flag; m_en = n_en; m_ev = n_ev; m_irq = n_irq;
      for (int k = HLEN - 1; k > 0; k--) h[k] = r ? 8'h00 : h[k-1];
      h[0] = r ? 8'h00 : sw;
      if (r) exp_q.delete();
      if (push) exp_q.push_back(rv);
      #1;
   endtask

   task automatic idle(input int n, input logic [7:0] sw);
      for (int i = 0; i < n; i++) cyc(1'b0, sw, 16'h0000, 1'b0, 1'b0, 16'h0000);
   endtask

   task automatic rd(input logic [15:0] a, input logic [7:0] sw);
      cyc(1'b0, sw, a, 1'b1, 1'b0, 16'h0000);
   endtask

   task automatic wr(input logic [15:0] a, input logic [15:0] d, input logic [7:0] sw);
      cyc(1'b0, sw, a, 1'b0, 1'b1, d);
   endtask

   // Monitor: checks every cycle, away from the active edge.
   logic [15:0] mon_exp;
   initial begin
      forever begin
         @(negedge clk);
         if (mon_en) begin
            vectors++;
            if (hit !== in_window(addr)) begin
               miscompares++;
               $display("FAIL hit addr=%h: got %b want %b", addr, hit, in_window(addr));
            end
            vectors++;
            if (irq !== m_irq) begin
               miscompares++;
               $display("FAIL irq @%0t: got %b want %b", $time, irq, m_irq);
            end
            vectors++;
            if (exp_q.size() > 0) begin
               mon_exp = exp_q.pop_front();
               if (rvalid !== 1'b1 || rdata !== mon_exp) begin
                  miscompares++;
                  $display("FAIL read @%0t: got rvalid=%b rdata=%h want rvalid=1 rdata=%h",
                           $time, rvalid, rdata, mon_exp);
               end
            end else if (rvalid !== 1'b0 || rdata !== 16'h0000) begin
               miscompares++;
               $display("FAIL idle @%0t: got rvalid=%b rdata=%h want rvalid=0 rdata=0000",
                        $time, rvalid, rdata);
            end
         end
      end
   end

   logic [7:0]  sw_cur;
   logic [15:0] ra, rwd;
   logic        rr, rrd, rwr;

   initial begin
      reset = 1'b1; switches = 8'h03; addr = '0; rd_en = 1'b0; wren = 1'b0; wdata = '0;

      // Reset with switches held at 03, then watch DATA appear.
      cyc(1'b1, 8'h03, 16'h0000, 1'b0, 1'b0, 16'h0000);
      mon_en = 1'b1;
      cyc(1'b1, 8'h03, 16'h0000, 1'b0, 1'b0, 16'h0000);
      for (int i = 0; i < 9; i++) rd(16'hFF00, 8'h03);
      rd(16'hFF01, 8'h03);
      rd(16'hFF03, 8'h03);

      // Settle at 02, then bounce bit0 every 2 cycles and settle at 03.
      for (int i = 0; i < 10; i++) rd(16'hFF00, 8'h02);
      for (int i = 0; i < 20; i++) rd(16'hFF00, ((i / 2) % 2 == 1) ? 8'h03 : 8'h02);
      for (int i = 0; i < 10; i++) rd(16'hFF00, 8'h03);
      rd(16'hFF03, 8'h03);

      // Back-to-back reads, then an out-of-window read.
      rd(16'hFF00, 8'h03);
      rd(16'hFF01, 8'h03);
      rd(16'hFF02, 8'h03);
      rd(16'hFF04, 8'h03);
      idle(2, 8'h03);

      // W1C on the very edge a change lands: the flag must survive.
      wr(16'hFF01, 16'h0001, 8'h5A);
      for (int i = 0; i < 12; i++) begin
         if (will_land()) cyc(1'b0, 8'h5A, 16'hFF01, 1'b1, 1'b1, 16'h0001);
         else idle(1, 8'h5A);
      end
      rd(16'hFF01, 8'h5A);
      wr(16'hFF01, 16'h0001, 8'h5A);
      rd(16'hFF01, 8'h5A);

      // Interrupt: enable, change 03 -> A5, clear, then clear EVCNT.
      idle(10, 8'h03);
      wr(16'hFF01, 16'h0001, 8'h03);
      wr(16'hFF01, 16'h0100, 8'h03);
      idle(10, 8'hA5);
      rd(16'hFF01, 8'hA5);
      wr(16'hFF01, 16'h0101, 8'hA5);
      idle(3, 8'hA5);
      wr(16'hFF03, 16'h0000, 8'hA5);
      rd(16'hFF03, 8'hA5);

      // Reset in the middle of a debounce.
      idle(2, 8'h3C);
      cyc(1'b1, 8'h3C, 16'h0000, 1'b0, 1'b0, 16'h0000);
      rd(16'hFF00, 8'h3C);
      rd(16'hFF01, 8'h3C);
      rd(16'hFF02, 8'h3C);
      rd(16'hFF03, 8'h3C);
      for (int i = 0; i < 8; i++) rd(16'hFF00, 8'h3C);

      // Randomized traffic against the model.
      sw_cur = 8'h3C;
      for (int i = 0; i < 3000; i++) begin
         rr = ($urandom_range(0, 299) == 0);
         if ($urandom_range(0, 15) == 0) sw_cur = 8'($urandom);
         else if ($urandom_range(0, 7) == 0) sw_cur = sw_cur ^ 8'(1 << $urandom_range(0, 7));
         ra  = ($urandom_range(0, 7) == 0) ? 16'($urandom)
                                          : 16'hFF00 + 16'($urandom_range(0, 5));
         rrd = 1'($urandom_range(0, 1));
         rwr = ($urandom_range(0, 3) == 0);
         rwd = 16'($urandom);
         if (will_land() && $urandom_range(0, 1) == 1) begin
            ra  = 16'hFF01;
            rwr = 1'b1;
            rwd = {7'b0, 1'($urandom_range(0, 1)), 8'h01};
         end
         cyc(rr, sw_cur, ra, rrd, rwr, rwd);
      end
      idle(2, sw_cur);

      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL drain: got %0d reads outstanding want 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
